// File: rtl/pll_seq_pkg.sv
// Shared state encodings and widths for the PLL reset sequencer.
package pll_seq_pkg;

    localparam int STATE_W  = 3;
    localparam int RELOCK_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } pll_state_t;

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop single-bit synchronizer with synchronous reset to 0.
module pll_lock_sync (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], d};
        end
    end

    assign q = sync_reg[1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: pulses pll_rst, waits for lock with timeout and retries,
// qualifies lock stability, then releases sys_rst; re-sequences on lock loss or request.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 17
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                locked,
    input  logic                relock_req,
    output logic                pll_rst,
    output logic                sys_rst,
    output logic                ready,
    output logic                fault,
    output logic [STATE_W-1:0]  state,
    output logic [RELOCK_W-1:0] relock_count
);

    localparam logic [STATE_W-1:0] S_RESET_PLL = ST_RESET_PLL;
    localparam logic [STATE_W-1:0] S_WAIT_LOCK = ST_WAIT_LOCK;
    localparam logic [STATE_W-1:0] S_STABLE    = ST_STABLE;
    localparam logic [STATE_W-1:0] S_RUN       = ST_RUN;
    localparam logic [STATE_W-1:0] S_FAULT     = ST_FAULT;

    localparam int RETRY_W = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST  = RETRY_W'(MAX_RETRIES - 1);

    logic                locked_s;
    logic [STATE_W-1:0]  state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [RETRY_W-1:0]  retry_cnt_reg, retry_cnt_next;
    logic [RELOCK_W-1:0] relock_cnt_reg, relock_cnt_next;
    logic                pll_rst_reg, sys_rst_reg, ready_reg, fault_reg;

    pll_lock_sync u_lock_sync (
        .clk  (refclk),
        .srst (rst),
        .d    (locked),
        .q    (locked_s)
    );

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        retry_cnt_next  = retry_cnt_reg;
        relock_cnt_next = relock_cnt_reg;
        case (state_reg)
            S_RESET_PLL: begin
                if (cnt_reg == RST_LAST) begin
                    state_next = S_WAIT_LOCK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_next = S_STABLE;
                    cnt_next   = '0;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    cnt_next = '0;
                    if (retry_cnt_reg == RETRY_LAST) begin
                        state_next = S_FAULT;
                    end else begin
                        state_next     = S_RESET_PLL;
                        retry_cnt_next = retry_cnt_reg + RETRY_W'(1);
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_STABLE: begin
                // A lock drop here restarts qualification without spending a retry.
                if (!locked_s) begin
                    state_next = S_WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt_reg == STABLE_LAST) begin
                    state_next     = S_RUN;
                    cnt_next       = '0;
                    retry_cnt_next = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (!locked_s || relock_req) begin
                    state_next = S_RESET_PLL;
                    cnt_next   = '0;
                    if (relock_cnt_reg != {RELOCK_W{1'b1}}) begin
                        relock_cnt_next = relock_cnt_reg + RELOCK_W'(1);
                    end
                end
            end
            S_FAULT: begin
                state_next = S_FAULT;
            end
            default: begin
                state_next = S_RESET_PLL;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs decode state_next so they change on the same edge as state_reg.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_reg      <= S_RESET_PLL;
            cnt_reg        <= '0;
            retry_cnt_reg  <= '0;
            relock_cnt_reg <= '0;
            pll_rst_reg    <= 1'b1;
            sys_rst_reg    <= 1'b1;
            ready_reg      <= 1'b0;
            fault_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            retry_cnt_reg  <= retry_cnt_next;
            relock_cnt_reg <= relock_cnt_next;
            pll_rst_reg    <= (state_next == S_RESET_PLL) || (state_next == S_FAULT);
            sys_rst_reg    <= (state_next != S_RUN);
            ready_reg      <= (state_next == S_RUN);
            fault_reg      <= (state_next == S_FAULT);
        end
    end

    assign pll_rst      = pll_rst_reg;
    assign sys_rst      = sys_rst_reg;
    assign ready        = ready_reg;
    assign fault        = fault_reg;
    assign state        = state_reg;
    assign relock_count = relock_cnt_reg;

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Controls the reset of a general-purpose PLL and monitors its lock. The PLL runs in direct mode, takes a 50 MHz refclk and provides a single outclk.
- Holds the PLL in reset, waits for lock with a timeout, and requires lock to stay stable before releasing the downstream system reset.
- Re-sequences the PLL on loss of lock or on software request.
- Runs on the free-running reference clock, beside the PLL wrapper at top level.

Parameters:
- RST_CYCLES, 16, refclk cycles pll_rst is held high per attempt (>=1).
- LOCK_TIMEOUT, 50000, refclk cycles allowed in WAIT_LOCK before an attempt fails (1 ms at 50 MHz).
- STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before RUN.
- MAX_RETRIES, 3, consecutive failed attempts before FAULT (>=1).
- CNT_W, 17, shared phase-counter width. Must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
- refclk  input  1  reference clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- locked  input  1  PLL lock flag, asynchronous to refclk.
- relock_req  input  1  single-cycle request to re-sequence the PLL; honoured only in RUN.
- pll_rst  output  1  drives the PLL reset input.
- sys_rst  output  1  active-high reset for logic clocked by outclk_0.
- ready  output  1  high only in RUN.
- fault  output  1  high only in FAULT.
- state  output  3  current state code, for debug.
- relock_count  output  8  saturating count of RUN exits.

Behaviour:
- Interface: one clock, refclk; reset rst is synchronous and active-high.
- Reset values (rst high at an edge): state=RESET_PLL, pll_rst=1, sys_rst=1, ready=0, fault=0, relock_count=0, retry_cnt=0, phase counter=0, sync flops=0. rst overrides everything, including mid-sequence and in FAULT.
- locked passes through a 2-flop synchronizer; locked_s lags locked by 2 cycles. Only locked_s is used.
- Outputs are registered Moore decodes of the state register, aligned with state:
  - pll_rst=1 in RESET_PLL and FAULT.
  - sys_rst=0 only in RUN.
  - ready=1 only in RUN.
  - fault=1 only in FAULT.
- Encodings: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.
- RESET_PLL: counter counts 0..RST_CYCLES-1. At RST_CYCLES-1, go to WAIT_LOCK and clear the counter. pll_rst is therefore high for exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - If locked_s=1, go to STABLE and clear the counter.
  - Else at counter=LOCK_TIMEOUT-1: if retry_cnt=MAX_RETRIES-1, go to FAULT; otherwise increment retry_cnt and go to RESET_PLL with the counter cleared.
  - locked_s takes priority over timeout in the same cycle.
- STABLE:
  - If locked_s=0, go to WAIT_LOCK and clear the counter. This does not consume a retry.
  - Else at counter=STABLE_CYCLES-1, go to RUN and clear retry_cnt.
  - Loss of lock takes priority over completion.
- RUN: if locked_s=0 or relock_req=1, go to RESET_PLL, clear the counter, and increment relock_count, saturating at 255. Both events in one cycle count as a single increment.
- FAULT: terminal; all outputs are held. Only rst exits.
- relock_req outside RUN is ignored, not queued.
- The counter does not wrap: each state transition clears it, and no state lets it exceed its bound.

Decomposition:
- Package pll_seq_pkg: state enum (3-bit, encodings above) and the STATE_W=3 and RELOCK_W=8 constants.
- One sub-module, pll_lock_sync: generic 2-flop bit synchronizer with synchronous reset to 0.
- FSM, counter and retry logic stay in pll_reset_sequencer.

Test Plan:
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2. Cycle 0 is the first edge after rst falls.
1. Clean bring-up: locked rises before the edge of cycle 8 and stays high.
   -> pll_rst=1 for cycles 0-3; WAIT_LOCK from cycle 4; locked_s first sampled high at the cycle-10 edge; STABLE from cycle 11.
   -> RUN, with sys_rst=0 and ready=1, from cycle 19; relock_count=0.
2. Lock glitch in STABLE: locked drops for 1 cycle mid-STABLE.
   -> returns to WAIT_LOCK, retry_cnt is not incremented, and the 8-cycle stable count restarts from zero.
3. Timeout and fault: locked held low.
   -> WAIT_LOCK times out after 20 cycles; second RESET_PLL pulse of 4 cycles; second timeout enters FAULT.
   -> fault=1, pll_rst=1, sys_rst=1 held; asserting locked afterwards has no effect.
4. Loss of lock in RUN: drop locked.
   -> exactly 3 cycles later sys_rst=1, pll_rst=1, relock_count=1; a full re-sequence then returns to RUN.
5. relock_req: pulse in RUN together with locked falling -> relock_count increments by exactly 1. Pulse in WAIT_LOCK -> ignored.
6. Saturation and reset mid-sequence: force 256 relocks -> relock_count=255. Then assert rst during STABLE -> all outputs at reset values on the next edge.
